register_file: RTL and testbench

//   RV32I integer register file: 2^AddrBitWidth x DataBitWidth registers, one write port, two registered read ports.

---
 rtl/register_file_if.sv | 26 ++
 rtl/register_file.sv | 115 +++++++++++
 tb/tb_register_file.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Register file port bundle: writeback write port, two read address/data pairs, ready.
// master: drives write request and read addresses; samples read data and ready.
// slave : the register file itself.
interface register_file_if #(
  parameter int AddrBitWidth = 5,
  parameter int DataBitWidth = 32
);
  logic                    wr_en;
  logic [AddrBitWidth-1:0] wr_addr;
  logic [DataBitWidth-1:0] wr_data;
  logic [AddrBitWidth-1:0] rs1_addr;
  logic [AddrBitWidth-1:0] rs2_addr;
  logic [DataBitWidth-1:0] rs1_data;
  logic [DataBitWidth-1:0] rs2_data;
  logic                    ready;

  modport master (
    output wr_en, wr_addr, wr_data, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, ready
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, ready
  );
endinterface

// File: rtl/register_file.sv
// RV32I integer register file: 2**AddrBitWidth x DataBitWidth, one write port, two registered read ports.
// Latency: reads return one edge after the address is presented; writes land on the same edge.
// Backpressure: none; ready stays low during the post-reset clear sweep and writes are dropped until it rises.
// Ports: clk, rst_n (synchronous, active-low), bus (register_file_if.slave: wr_en/wr_addr/wr_data,
//        rs1_addr/rs2_addr in; rs1_data/rs2_data/ready out).
module register_file #(
  parameter int AddrBitWidth = 5,
  parameter int DataBitWidth = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  register_file_if.slave bus
);

  localparam int NumRegs = 2 ** AddrBitWidth;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [AddrBitWidth-1:0] LastIdx = AddrBitWidth'(NumRegs - 1);

  logic [0:0]              state_q, state_d;
  logic [AddrBitWidth-1:0] clr_idx_q, clr_idx_d;
  logic                    ready_q, ready_d;
  logic [DataBitWidth-1:0] rs1_data_q, rs1_data_d;
  logic [DataBitWidth-1:0] rs2_data_q, rs2_data_d;
  logic [DataBitWidth-1:0] regs_q [NumRegs];
  logic [DataBitWidth-1:0] regs_d [NumRegs];

  logic               we_eff;
  logic [NumRegs-1:0] dec_onehot;
  logic [NumRegs-1:0] row_en;

  // Write decoder: one-hot row select gated by the effective write enable.
  // x0 is never written, so its row stays meaningless and reads of it are forced to 0.
  always_comb begin
    dec_onehot = '0;
    dec_onehot[bus.wr_addr] = 1'b1;
  end

  assign we_eff = ready_q & bus.wr_en & (bus.wr_addr != '0);
  assign row_en = dec_onehot & {NumRegs{we_eff}};

  // Storage update: normal writes in RUN, one zeroed entry per cycle in CLEAR.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NumRegs; i++) begin
      if (row_en[i]) begin
        regs_d[i] = bus.wr_data;
      end
    end
    if (state_q == ST_CLEAR) begin
      regs_d[clr_idx_q] = '0;
    end
  end

  // Clear sequencer; starts at index 1 since x0 is hardwired to read 0.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    if (state_q == ST_CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == LastIdx) begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end
    end
  end

  // Read ports with write-first bypass so a same-edge write is visible immediately.
  always_comb begin
    rs1_data_d = regs_q[bus.rs1_addr];
    if (!ready_q || bus.rs1_addr == '0) begin
      rs1_data_d = '0;
    end else if (we_eff && bus.wr_addr == bus.rs1_addr) begin
      rs1_data_d = bus.wr_data;
    end

    rs2_data_d = regs_q[bus.rs2_addr];
    if (!ready_q || bus.rs2_addr == '0) begin
      rs2_data_d = '0;
    end else if (we_eff && bus.wr_addr == bus.rs2_addr) begin
      rs2_data_d = bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_idx_q  <= AddrBitWidth'(1);
      ready_q    <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      ready_q    <= ready_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
    end
  end

  // Array has no reset; the clear sweep zeroes it. Held during reset so nothing lands mid-reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      regs_q <= regs_d;
    end
  end

  assign bus.rs1_data = rs1_data_q;
  assign bus.rs2_data = rs2_data_q;
  assign bus.ready    = ready_q;

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  register_file_if #(.AddrBitWidth(AW), .DataBitWidth(DW)) bus ();

  register_file #(.AddrBitWidth(AW), .DataBitWidth(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: architectural register contents, ready after NR-1 clean edges
  // following reset, write-then-read ordering within one edge.
  logic [DW-1:0] mem [NR];
  bit            m_ready;
  int            m_edges;
  logic [DW-1:0] exp_rs1, exp_rs2;
  logic          exp_ready;
  bit            chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) mem[i] = '0;
      m_ready   = 1'b0;
      m_edges   = 0;
      exp_rs1   = '0;
      exp_rs2   = '0;
      exp_ready = 1'b0;
      chk_en    = 1'b1;
    end else begin
      if (m_ready && bus.wr_en && bus.wr_addr != 0) mem[bus.wr_addr] = bus.wr_data;
      exp_rs1 = (m_ready && bus.rs1_addr != 0) ? mem[bus.rs1_addr] : '0;
      exp_rs2 = (m_ready && bus.rs2_addr != 0) ? mem[bus.rs2_addr] : '0;
      if (!m_ready) begin
        m_edges++;
        if (m_edges == NR - 1) m_ready = 1'b1;
      end
      exp_ready = m_ready;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_rs1",   bus.rs1_data, exp_rs1);
      check("cmp_rs2",   bus.rs2_data, exp_rs2);
      check("cmp_ready", {31'b0, bus.ready}, {31'b0, exp_ready});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [DW-1:0] v1, v2;
    rst_n        = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
    cyc();
    cyc();
    check("rst_ready", {31'b0, bus.ready}, 32'h0);
    check("rst_rs1",   bus.rs1_data, 32'h0);
    check("rst_rs2",   bus.rs2_data, 32'h0);

    // Sweep: ready only after the 31st edge; a write on the 10th edge is dropped.
    rst_n = 1'b1;
    for (int e = 1; e <= 31; e++) begin
      bus.wr_en    = (e == 10);
      bus.wr_addr  = 5'd3;
      bus.wr_data  = 32'hA5A5A5A5;
      bus.rs1_addr = AW'(e);
      bus.rs2_addr = 5'd31;
      cyc();
      check("sweep_ready", {31'b0, bus.ready}, (e == 31) ? 32'h1 : 32'h0);
      check("sweep_rs1",   bus.rs1_data, 32'h0);
    end
    bus.wr_en = 1'b0;

    // Write x5 then read it.
    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF;
    cyc();
    bus.wr_en = 1'b0; bus.rs1_addr = 5'd5;
    cyc();
    check("x5_read", bus.rs1_data, 32'hDEADBEEF);

    // Write to x0 is discarded.
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFFFFFF;
    bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0;
    cyc();
    check("x0_same_rs1", bus.rs1_data, 32'h0);
    bus.wr_en = 1'b0;
    cyc();
    check("x0_rs1", bus.rs1_data, 32'h0);
    check("x0_rs2", bus.rs2_data, 32'h0);

    // Same-edge write and read: bypass on both ports.
    bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h12345678;
    bus.rs1_addr = 5'd7; bus.rs2_addr = 5'd7;
    cyc();
    check("byp_rs1", bus.rs1_data, 32'h12345678);
    check("byp_rs2", bus.rs2_data, 32'h12345678);
    bus.wr_en = 1'b0;
    cyc();
    check("x7_stored", bus.rs1_data, 32'h12345678);

    // Write dropped during sweep left x3 at zero.
    bus.rs1_addr = 5'd3;
    cyc();
    check("x3_dropped", bus.rs1_data, 32'h0);

    // Fill every register, read back through both ports.
    for (int i = 1; i < NR; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = AW'(i); bus.wr_data = 32'(i) * 32'h01010101;
      cyc();
    end
    bus.wr_en = 1'b0;
    for (int i = 0; i < NR; i++) begin
      bus.rs1_addr = AW'(i);
      bus.rs2_addr = AW'(NR - 1 - i);
      cyc();
      v1 = 32'(i) * 32'h01010101;
      v2 = 32'(NR - 1 - i) * 32'h01010101;
      check("fill_rs1", bus.rs1_data, v1);
      check("fill_rs2", bus.rs2_data, v2);
    end

    // Mid-operation reset: a write presented during reset must not land.
    rst_n = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h99999999;
    bus.rs1_addr = 5'd9;
    cyc();
    check("mid_rst_ready", {31'b0, bus.ready}, 32'h0);
    check("mid_rst_rs1",   bus.rs1_data, 32'h0);
    rst_n = 1'b1;
    bus.wr_en = 1'b0;
    for (int e = 1; e <= 31; e++) begin
      cyc();
      check("resweep_ready", {31'b0, bus.ready}, (e == 31) ? 32'h1 : 32'h0);
    end
    cyc();
    check("x9_after_resweep", bus.rs1_data, 32'h0);
    bus.rs1_addr = 5'd20;
    cyc();
    check("x20_after_resweep", bus.rs1_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
